segasys1_sprcoll_ram: RTL and testbench

- Receiving end of the sprite engine's collision report interface (sprcoll strobe plus sprcoll_ad).
- Latches every reported sprite-vs-sprite hit into a 1024x1 collision RAM and a sticky summary flag.
- Both are exposed to the main CPU, which reads hits and clears them by writing.
- Sits between the sprite renderer and the CPU address decoder; runs on the sprite renderer's VCLKx4 domain.

---
 rtl/segasys1_pkg.sv | 12 +
 rtl/segasys1_pend_fifo.sv | 63 ++++++
 rtl/segasys1_sprcoll_ram.sv | 162 ++++++++++++++++
 tb/tb_segasys1_sprcoll_ram.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/segasys1_pkg.sv
// Shared constants and types for the Sega System 1 sprite collision block.
package segasys1_pkg;

    localparam int         COLL_ADDR_W = 10;
    localparam logic [6:0] COLL_RD_PAD = 7'b1111111;

    typedef enum logic {
        INIT_CLR,
        RUN
    } coll_state_t;

endpackage

// File: rtl/segasys1_pend_fifo.sv
// Small synchronous FIFO that parks sprite sets while the collision RAM
// write port is busy with a CPU clear or an earlier parked set.
module segasys1_pend_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers and occupancy; reset flushes the queue without touching storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/segasys1_sprcoll_ram.sv
// Collision report receiver: latches sprite-vs-sprite hits into a 1-bit RAM
// plus a sticky summary flag, both readable and clearable by the main CPU.
module segasys1_sprcoll_ram
    import segasys1_pkg::*;
#(
    parameter int ADDR_W     = COLL_ADDR_W,
    parameter int PEND_DEPTH = 2
) (
    input  logic              VCLKx4,
    input  logic              RESET,
    input  logic              sprcoll,
    input  logic [ADDR_W-1:0] sprcoll_ad,
    input  logic              cpu_cs_coll,
    input  logic              cpu_cs_sum,
    input  logic [ADDR_W-1:0] cpu_ad,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [7:0]        cpu_dout,
    output logic              busy,
    output logic              ovf
);

    localparam int                RAM_DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    coll_state_t       state;
    coll_state_t       state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic              summary;
    logic              mem [RAM_DEPTH];

    logic              we;
    logic [ADDR_W-1:0] wa;
    logic              wd;
    logic              cpu_clr;
    logic              set_accept;
    logic              set_drop;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] fifo_head;

    assign cpu_clr = cpu_wr & cpu_cs_coll;
    assign busy    = (state == INIT_CLR);

    segasys1_pend_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (PEND_DEPTH)
    ) u_pend_fifo (
        .clk   (VCLKx4),
        .rst   (RESET),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (sprcoll_ad),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Next state and single write-port arbitration: CPU clear, then parked set, then direct set.
    always_comb begin
        state_next = state;
        we         = 1'b0;
        wa         = '0;
        wd         = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        set_accept = 1'b0;
        set_drop   = 1'b0;
        case (state)
            INIT_CLR: begin
                we = 1'b1;
                wa = clr_cnt;
                wd = 1'b0;
                if (clr_cnt == LAST_ADDR) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cpu_clr) begin
                    we = 1'b1;
                    wa = cpu_ad;
                    wd = 1'b0;
                end else if (!fifo_empty) begin
                    we       = 1'b1;
                    wa       = fifo_head;
                    wd       = 1'b1;
                    fifo_pop = 1'b1;
                end else if (sprcoll) begin
                    we         = 1'b1;
                    wa         = sprcoll_ad;
                    wd         = 1'b1;
                    set_accept = 1'b1;
                end
                if (sprcoll && (cpu_clr || !fifo_empty)) begin
                    if (fifo_full) begin
                        set_drop = 1'b1;
                    end else begin
                        fifo_push  = 1'b1;
                        set_accept = 1'b1;
                    end
                end
            end
            default: state_next = INIT_CLR;
        endcase
    end

    // State register and post-reset sweep counter.
    always_ff @(posedge VCLKx4 or posedge RESET) begin
        if (RESET) begin
            state   <= INIT_CLR;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == INIT_CLR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Sticky summary (a set beats a same-cycle clear) and sticky overflow flag.
    always_ff @(posedge VCLKx4 or posedge RESET) begin
        if (RESET) begin
            summary <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (set_accept) begin
                summary <= 1'b1;
            end else if (state == RUN && cpu_wr && cpu_cs_sum) begin
                summary <= 1'b0;
            end
            if (set_drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Read data register; sampling the RAM here gives old data on a same-cycle write.
    always_ff @(posedge VCLKx4 or posedge RESET) begin
        if (RESET) begin
            cpu_dout <= 8'hFF;
        end else if (cpu_rd && (cpu_cs_coll || cpu_cs_sum)) begin
            if (state == INIT_CLR) begin
                cpu_dout <= 8'hFF;
            end else if (cpu_cs_coll) begin
                cpu_dout <= {COLL_RD_PAD, mem[cpu_ad]};
            end else begin
                cpu_dout <= {COLL_RD_PAD, summary};
            end
        end
    end

    // Collision RAM write port; contents are initialised by the sweep, not by reset.
    always_ff @(posedge VCLKx4) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

endmodule

// File: tb/tb_segasys1_sprcoll_ram.sv
// Directed self-checking bench for the sprite collision RAM.
module tb_segasys1_sprcoll_ram;

    logic       VCLKx4;
    logic       RESET;
    logic       sprcoll;
    logic [9:0] sprcoll_ad;
    logic       cpu_cs_coll;
    logic       cpu_cs_sum;
    logic [9:0] cpu_ad;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] cpu_dout;
    logic       busy;
    logic       ovf;

    int         n_checks;
    int         n_fail;
    int         busy_cycles;
    logic [7:0] rd_data;

    segasys1_sprcoll_ram dut (
        .VCLKx4      (VCLKx4),
        .RESET       (RESET),
        .sprcoll     (sprcoll),
        .sprcoll_ad  (sprcoll_ad),
        .cpu_cs_coll (cpu_cs_coll),
        .cpu_cs_sum  (cpu_cs_sum),
        .cpu_ad      (cpu_ad),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_dout    (cpu_dout),
        .busy        (busy),
        .ovf         (ovf)
    );

    // Free-running sprite renderer clock.
    initial VCLKx4 = 1'b0;
    always #5 VCLKx4 = ~VCLKx4;

    // Drive one cycle of inputs at the falling edge; the next rising edge consumes them.
    task automatic applyStimulus(input logic s, input logic [9:0] s_ad,
                                 input logic cs_c, input logic cs_s,
                                 input logic [9:0] ad, input logic rd, input logic wr);
        @(negedge VCLKx4);
        sprcoll     = s;
        sprcoll_ad  = s_ad;
        cpu_cs_coll = cs_c;
        cpu_cs_sum  = cs_s;
        cpu_ad      = ad;
        cpu_rd      = rd;
        cpu_wr      = wr;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic readColl(input logic [9:0] ad, output logic [7:0] d);
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b0, ad, 1'b1, 1'b0);
        idleCycle();
        d = cpu_dout;
    endtask

    task automatic readSum(output logic [7:0] d);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1, 10'h000, 1'b1, 1'b0);
        idleCycle();
        d = cpu_dout;
    endtask

    // Count rising edges with busy high, starting at the falling edge where RESET drops.
    // A strobe and a read are issued mid-sweep; both must be ignored.
    task automatic sweepCount(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            sprcoll     = (n == 5);
            sprcoll_ad  = 10'h005;
            cpu_cs_coll = (n == 5);
            cpu_ad      = 10'h005;
            cpu_rd      = (n == 5);
            @(negedge VCLKx4);
            n++;
            if (n == 6) begin
                checkOutput("init_rd_ff", {24'h0, cpu_dout}, 32'hFF);
            end
        end
        sprcoll     = 1'b0;
        cpu_cs_coll = 1'b0;
        cpu_rd      = 1'b0;
    endtask

    task automatic checkAllClear(input string tag);
        logic [7:0] d;
        for (int a = 0; a < 1024; a++) begin
            readColl(10'(a), d);
            checkOutput($sformatf("%s_%0h", tag, a), {24'h0, d}, 32'hFE);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        RESET       = 1'b1;
        sprcoll     = 1'b0;
        sprcoll_ad  = '0;
        cpu_cs_coll = 1'b0;
        cpu_cs_sum  = 1'b0;
        cpu_ad      = '0;
        cpu_rd      = 1'b0;
        cpu_wr      = 1'b0;

        $display("[TB] reset values");
        repeat (3) @(negedge VCLKx4);
        checkOutput("rst_busy", {31'h0, busy}, 32'h1);
        checkOutput("rst_ovf", {31'h0, ovf}, 32'h0);
        checkOutput("rst_dout", {24'h0, cpu_dout}, 32'hFF);

        $display("[TB] post-reset sweep");
        RESET = 1'b0;
        sweepCount(busy_cycles);
        checkOutput("sweep_len", busy_cycles, 32'd1024);
        checkOutput("sweep_ovf", {31'h0, ovf}, 32'h0);
        checkAllClear("sweep_rd");
        readSum(rd_data);
        checkOutput("sweep_sum", {24'h0, rd_data}, 32'hFE);

        $display("[TB] basic set");
        applyStimulus(1'b1, 10'h155, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
        idleCycle();
        readColl(10'h155, rd_data);
        checkOutput("set_155", {24'h0, rd_data}, 32'hFF);
        readColl(10'h154, rd_data);
        checkOutput("set_154", {24'h0, rd_data}, 32'hFE);
        readSum(rd_data);
        checkOutput("set_sum", {24'h0, rd_data}, 32'hFF);

        $display("[TB] cs_coll wins over cs_sum on read");
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b1, 10'h154, 1'b1, 1'b0);
        idleCycle();
        checkOutput("cs_prio", {24'h0, cpu_dout}, 32'hFE);
        idleCycle();
        checkOutput("dout_hold", {24'h0, cpu_dout}, 32'hFE);

        $display("[TB] clear");
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b0, 10'h155, 1'b0, 1'b1);
        readColl(10'h155, rd_data);
        checkOutput("clr_155", {24'h0, rd_data}, 32'hFE);
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1, 10'h000, 1'b0, 1'b1);
        readSum(rd_data);
        checkOutput("clr_sum", {24'h0, rd_data}, 32'hFE);

        $display("[TB] same-address clear and set");
        applyStimulus(1'b1, 10'h0A0, 1'b1, 1'b0, 10'h0A0, 1'b0, 1'b1);
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b0, 10'h0A0, 1'b1, 1'b0);
        idleCycle();
        checkOutput("rbw_0a0", {24'h0, cpu_dout}, 32'hFE);
        readColl(10'h0A0, rd_data);
        checkOutput("coll_0a0", {24'h0, rd_data}, 32'hFF);
        readSum(rd_data);
        checkOutput("coll_sum", {24'h0, rd_data}, 32'hFF);

        $display("[TB] summary set beats clear");
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1, 10'h000, 1'b0, 1'b1);
        readSum(rd_data);
        checkOutput("sum_cleared", {24'h0, rd_data}, 32'hFE);
        applyStimulus(1'b1, 10'h010, 1'b0, 1'b1, 10'h000, 1'b0, 1'b1);
        readSum(rd_data);
        checkOutput("sum_setwins", {24'h0, rd_data}, 32'hFF);
        readColl(10'h010, rd_data);
        checkOutput("set_010", {24'h0, rd_data}, 32'hFF);

        $display("[TB] pending FIFO stress");
        applyStimulus(1'b1, 10'h001, 1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1);
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1);
        applyStimulus(1'b1, 10'h002, 1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1);
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1);
        checkOutput("ovf_before", {31'h0, ovf}, 32'h0);
        applyStimulus(1'b1, 10'h003, 1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1);
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1);
        checkOutput("ovf_set", {31'h0, ovf}, 32'h1);
        idleCycle();
        idleCycle();
        idleCycle();
        readColl(10'h001, rd_data);
        checkOutput("fifo_001", {24'h0, rd_data}, 32'hFF);
        readColl(10'h002, rd_data);
        checkOutput("fifo_002", {24'h0, rd_data}, 32'hFF);
        readColl(10'h003, rd_data);
        checkOutput("fifo_003_dropped", {24'h0, rd_data}, 32'hFE);
        checkOutput("ovf_sticky", {31'h0, ovf}, 32'h1);

        $display("[TB] reset mid-sweep");
        @(negedge VCLKx4);
        RESET = 1'b1;
        @(negedge VCLKx4);
        checkOutput("rst2_busy", {31'h0, busy}, 32'h1);
        checkOutput("rst2_ovf", {31'h0, ovf}, 32'h0);
        checkOutput("rst2_dout", {24'h0, cpu_dout}, 32'hFF);
        RESET = 1'b0;
        for (int i = 0; i < 500; i++) begin
            sprcoll    = (i % 2 == 0);
            sprcoll_ad = 10'(i);
            @(negedge VCLKx4);
        end
        sprcoll    = 1'b1;
        sprcoll_ad = 10'h1F4;
        RESET      = 1'b1;
        @(negedge VCLKx4);
        sprcoll = 1'b0;
        RESET   = 1'b0;
        sweepCount(busy_cycles);
        checkOutput("sweep2_len", busy_cycles, 32'd1024);
        checkOutput("sweep2_ovf", {31'h0, ovf}, 32'h0);
        readSum(rd_data);
        checkOutput("sweep2_sum", {24'h0, rd_data}, 32'hFE);
        checkAllClear("sweep2_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
